// File: rtl/countdown_pkg.sv
// countdown_pkg
// Shared definitions for the two-digit countdown controller: the FSM state
// encoding, the BCD digit width/limit and small BCD helpers used by the
// controller.
// Ports: none (package).

package countdown_pkg;

  localparam int              BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  // Two BCD digits kept together so the pair can be compared against 00/01.
  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd2_t;

  // Preset switches can present 0xA..0xF; those read as 9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  // Two-digit BCD decrement with borrow from ones into tens; 00 stays 00.
  function automatic bcd2_t bcd_dec(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.tens == '0 && v.ones == '0) begin
      r = v;
    end else if (v.ones == '0) begin
      r.ones = BCD_MAX;
      r.tens = v.tens - 1'b1;
    end else begin
      r.ones = v.ones - 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_tick_gen.sv
// countdown_tick_gen
// Prescaler producing the count tick: counts 0..TICK_DIV-1 while enabled,
// holds when disabled, and is forced to 0 by clear (clear beats enable).
// Ports:
//   clock  - system clock, rising edge
//   reset  - synchronous, active-low reset
//   enable - advance the prescaler this cycle
//   clear  - force the prescaler to 0 at the next edge
//   tick   - high while enabled and the count is at TICK_DIV-1

module countdown_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int               CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // tick is qualified by enable so a held count never fires while paused.
  assign tick = enable && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl
// Sequencing controller for the two-digit countdown: holds the BCD count,
// owns the 1 s tick prescaler and runs the IDLE/RUN/PAUSE/ALARM machine.
// All outputs are registered; a button pulse takes effect at the next edge.
// Optional build macro: COUNTDOWN_AUTO_RELOAD_EN - when defined, an ALARM
// that times out reloads the preset and restarts (if the preset is non-zero).
// Ports:
//   clock, reset            - clock and synchronous active-low reset
//   start_btn/pause_btn/load_btn - single-cycle debounced button pulses
//   preset_tens/preset_ones - preset digits (values above 9 read as 9)
//   digit1/digit0           - current tens/ones BCD digits
//   running                 - high while counting
//   done                    - one-cycle pulse when the count reaches 00
//   beep                    - buzzer enable, high in ALARM

module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int BEEP_TICKS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       load_btn,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       running,
  output logic       done,
  output logic       beep
);

  localparam int              BC_W      = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS + 1) : 1;
  localparam logic [BC_W-1:0] BEEP_LAST = BC_W'(BEEP_TICKS - 1);

  state_t          state_q, state_d;
  bcd2_t           digits_q, digits_d;
  logic [BC_W-1:0] beep_cnt_q, beep_cnt_d;
  logic            running_q, running_d;
  logic            done_q, done_d;
  logic            beep_q, beep_d;

  logic  presc_en;
  logic  presc_clr;
  logic  tick;
  bcd2_t preset;

  assign preset.tens = bcd_clamp(preset_tens);
  assign preset.ones = bcd_clamp(preset_ones);

  countdown_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .enable(presc_en),
    .clear (presc_clr),
    .tick  (tick)
  );

  // Next-state logic. The prescaler does not advance on the cycle a pause
  // is accepted, so a pause landing on a tick keeps the count at its last
  // value and resuming finishes the interrupted period instead of a new one.
  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    beep_cnt_d = beep_cnt_q;
    done_d     = 1'b0;
    presc_en   = 1'b0;
    presc_clr  = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_btn) begin
          digits_d = preset;
        end else if (start_btn && digits_q != '0) begin
          state_d   = RUN;
          presc_clr = 1'b1;
        end
      end

      RUN: begin
        presc_en = !pause_btn;
        if (pause_btn) begin
          state_d = PAUSE;
        end else if (tick && digits_q != '0) begin
          digits_d = bcd_dec(digits_q);
          if (digits_q == 8'h01) begin
            state_d    = ALARM;
            done_d     = 1'b1;
            presc_clr  = 1'b1;
            beep_cnt_d = '0;
          end
        end
      end

      PAUSE: begin
        if (load_btn) begin
          digits_d  = preset;
          presc_clr = 1'b1;
          state_d   = IDLE;
        end else if (start_btn) begin
          state_d = RUN;
        end
      end

      ALARM: begin
        presc_en = 1'b1;
        if (load_btn || pause_btn) begin
          state_d    = IDLE;
          beep_cnt_d = '0;
          if (load_btn) begin
            digits_d = preset;
          end
        end else if (tick) begin
          if (beep_cnt_q == BEEP_LAST) begin
            beep_cnt_d = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            digits_d = preset;
            if (preset != '0) begin
              state_d   = RUN;
              presc_clr = 1'b1;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end else begin
            beep_cnt_d = beep_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    running_d = (state_d == RUN);
    beep_d    = (state_d == ALARM);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      digits_q   <= '0;
      beep_cnt_q <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      beep_cnt_q <= beep_cnt_d;
      running_q  <= running_d;
      done_q     <= done_d;
      beep_q     <= beep_d;
    end
  end

  assign digit1  = digits_q.tens;
  assign digit0  = digits_q.ones;
  assign running = running_q;
  assign done    = done_q;
  assign beep    = beep_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl
// Self-checking bench for countdown_ctrl with TICK_DIV=4, BEEP_TICKS=2.
// A value-level model (count held as an integer 0..99) predicts the outputs
// every cycle; directed scenarios add hand-computed literal expectations,
// followed by a randomized button/preset phase.

module tb_countdown_ctrl;

  localparam int TDIV  = 4;
  localparam int BEEPS = 2;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_ALARM = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic       load_btn = 1'b0;
  logic [3:0] preset_tens = 4'd0;
  logic [3:0] preset_ones = 4'd0;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic       running;
  logic       done;
  logic       beep;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  // Model state: mode, count value as an integer, elapsed prescaler
  // cycles in the current period, ticks seen in ALARM, done pulse.
  int m_mode = M_IDLE;
  int m_val = 0;
  int m_pre = 0;
  int m_beeps = 0;
  bit m_done = 1'b0;
  int m_preset;
  bit m_tick;

  countdown_ctrl #(
    .TICK_DIV  (TDIV),
    .BEEP_TICKS(BEEPS)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start_btn  (start_btn),
    .pause_btn  (pause_btn),
    .load_btn   (load_btn),
    .preset_tens(preset_tens),
    .preset_ones(preset_ones),
    .digit1     (digit1),
    .digit0     (digit0),
    .running    (running),
    .done       (done),
    .beep       (beep)
  );

  always #5 clock = ~clock;

  function automatic int clampd(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  // Behavioural model: the count is an integer; a tick is every TDIV-th
  // counting cycle; reaching zero raises the alarm.
  always @(posedge clock) begin
    m_preset = clampd(preset_tens) * 10 + clampd(preset_ones);
    m_tick   = (m_pre == TDIV - 1);
    m_done   = 1'b0;
    if (!reset) begin
      m_mode  = M_IDLE;
      m_val   = 0;
      m_pre   = 0;
      m_beeps = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (load_btn) m_val = m_preset;
          else if (start_btn && m_val != 0) begin
            m_mode = M_RUN;
            m_pre  = 0;
          end
        end
        M_RUN: begin
          if (pause_btn) m_mode = M_PAUSE;
          else if (m_tick) begin
            m_pre = 0;
            m_val = m_val - 1;
            if (m_val == 0) begin
              m_mode  = M_ALARM;
              m_done  = 1'b1;
              m_beeps = 0;
            end
          end else m_pre = m_pre + 1;
        end
        M_PAUSE: begin
          if (load_btn) begin
            m_val  = m_preset;
            m_pre  = 0;
            m_mode = M_IDLE;
          end else if (start_btn) m_mode = M_RUN;
        end
        default: begin
          if (load_btn || pause_btn) begin
            if (load_btn) m_val = m_preset;
            m_mode = M_IDLE;
          end else if (m_tick) begin
            m_pre   = 0;
            m_beeps = m_beeps + 1;
            if (m_beeps == BEEPS) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              m_val  = m_preset;
              m_mode = (m_preset != 0) ? M_RUN : M_IDLE;
`else
              m_mode = M_IDLE;
`endif
            end
          end else m_pre = m_pre + 1;
        end
      endcase
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (checking) begin
      checkOutput("model_digit1", int'(digit1), m_val / 10);
      checkOutput("model_digit0", int'(digit0), m_val % 10);
      checkOutput("model_running", int'(running), int'(m_mode == M_RUN));
      checkOutput("model_done", int'(done), int'(m_done));
      checkOutput("model_beep", int'(beep), int'(m_mode == M_ALARM));
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit s, input bit p, input bit l);
    start_btn = s;
    pause_btn = p;
    load_btn  = l;
    waitCycles(1);
    start_btn = 1'b0;
    pause_btn = 1'b0;
    load_btn  = 1'b0;
  endtask

  task automatic setPreset(input int t, input int o);
    preset_tens = 4'(t);
    preset_ones = 4'(o);
  endtask

  initial begin
    // Scenario 1: reset held for two cycles.
    reset = 1'b0;
    waitCycles(1);
    checking = 1'b1;
    waitCycles(1);
    reset = 1'b1;
    checkOutput("rst_digit1", int'(digit1), 0);
    checkOutput("rst_digit0", int'(digit0), 0);
    checkOutput("rst_running", int'(running), 0);
    checkOutput("rst_beep", int'(beep), 0);
    checkOutput("rst_done", int'(done), 0);
    applyStimulus(1, 0, 0);
    checkOutput("start_at_00_running", int'(running), 0);

    // Scenario 2/3: count 12 down to 00, then the alarm timeout.
    setPreset(1, 2);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    checkOutput("run_running", int'(running), 1);
    waitCycles(4);
    checkOutput("step11_tens", int'(digit1), 1);
    checkOutput("step11_ones", int'(digit0), 1);
    waitCycles(8);
    checkOutput("borrow09_tens", int'(digit1), 0);
    checkOutput("borrow09_ones", int'(digit0), 9);
    waitCycles(36);
    checkOutput("zero_digit0", int'(digit0), 0);
    checkOutput("zero_done", int'(done), 1);
    checkOutput("zero_beep", int'(beep), 1);
    waitCycles(1);
    checkOutput("done_one_cycle", int'(done), 0);
    waitCycles(6);
    checkOutput("beep_last_cycle", int'(beep), 1);
    waitCycles(1);
    checkOutput("beep_off", int'(beep), 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    checkOutput("reload_ones", int'(digit0), 2);
    checkOutput("reload_running", int'(running), 1);
`else
    checkOutput("idle_ones", int'(digit0), 0);
    checkOutput("idle_running", int'(running), 0);
`endif

    // Scenario 4: pause exactly on the tick cycle, then resume.
    setPreset(0, 5);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    waitCycles(3);
    applyStimulus(0, 1, 0);
    checkOutput("pause_ones", int'(digit0), 5);
    checkOutput("pause_running", int'(running), 0);
    waitCycles(10);
    applyStimulus(1, 0, 0);
    checkOutput("resume_ones", int'(digit0), 5);
    waitCycles(1);
    checkOutput("resume_remaining", int'(digit0), 4);

    // Scenario 5: clamping and the 00 start guard.
    applyStimulus(0, 1, 0);
    setPreset(12, 15);
    applyStimulus(0, 0, 1);
    checkOutput("clamp_tens", int'(digit1), 9);
    checkOutput("clamp_ones", int'(digit0), 9);
    setPreset(0, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    checkOutput("zero_start_running", int'(running), 0);

    // Scenario 6: early alarm exit and reset mid-run.
    setPreset(0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    waitCycles(4);
    checkOutput("alarm_beep", int'(beep), 1);
    waitCycles(2);
    applyStimulus(0, 1, 0);
    checkOutput("silence_beep", int'(beep), 0);
    checkOutput("silence_running", int'(running), 0);
    setPreset(3, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    waitCycles(5);
    reset = 1'b0;
    waitCycles(1);
    reset = 1'b1;
    checkOutput("midrun_rst_tens", int'(digit1), 0);
    checkOutput("midrun_rst_running", int'(running), 0);

    // Randomized phase: small presets so alarms are reached often.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        preset_tens = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        preset_ones = 4'($urandom_range(0, 15));
      end
      start_btn = ($urandom_range(0, 9) == 0);
      pause_btn = ($urandom_range(0, 29) == 0);
      load_btn  = ($urandom_range(0, 24) == 0);
      reset     = ($urandom_range(0, 999) != 0);
      waitCycles(1);
    end
    start_btn = 1'b0;
    pause_btn = 1'b0;
    load_btn  = 1'b0;
    reset     = 1'b1;
    waitCycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
